// File: rtl/regs_wr_arbiter_pkg.sv
// Shared types and constants for the Regs_8_32 write-port arbiter.
// REGS_ARB_RR_EN selects round-robin arbitration (fixed priority otherwise).
package regs_arb_pkg;

  typedef enum logic {
    IDLE,
    CLR
  } state_e;

  localparam int NREGS    = 8;
  localparam int DEF_AW   = 3;
  localparam int DEF_DW   = 32;
  localparam int DEF_NREQ = 4;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/regs_wr_arbiter_if.sv
// Requester/register-file bundle around the write-port arbiter.
// master = requester side, slave = arbiter side.
interface regs_wr_arbiter_if
  import regs_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) ();

  logic [NREQ-1:0]    req;
  logic [AW*NREQ-1:0] wr_addr;
  logic [DW*NREQ-1:0] wr_data;
  logic               clr_req;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               clr_done;
  logic               WE;
  logic [AW-1:0]      Addr_W;
  logic [DW-1:0]      Di;

  modport master (
    output req, wr_addr, wr_data, clr_req,
    input  gnt, busy, clr_done, WE, Addr_W, Di
  );

  modport slave (
    input  req, wr_addr, wr_data, clr_req,
    output gnt, busy, clr_done, WE, Addr_W, Di
  );

endinterface

// File: rtl/regs_wr_arbiter_rr_pick.sv
// Combinational picker: first set request at or after start, wrapping.
// Used with start=0 it degenerates to lowest-index priority.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  win_o,
  output logic          valid_o
);

  int j;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j[IW-1:0]]) begin
        win_o[j[IW-1:0]] = 1'b1;
        valid_o          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regs_wr_arbiter.sv
// Write-port arbiter and clear sequencer for Regs_8_32.
// Define REGS_ARB_RR_EN for round-robin; default is fixed priority.
module regs_wr_arbiter
  import regs_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input logic              clk,
  input logic              cr,
  regs_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   di_q, di_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            done_q, done_d;

  logic [NREQ-1:0] win;
  logic            win_v;
  logic [IW-1:0]   start;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            clr_go;
  logic            grant_go;

  // a requester on the port this cycle must re-present before competing
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i  (bus.req & ~gnt_q),
    .start_i(start),
    .win_o  (win),
    .valid_o(win_v)
  );

  // clr_req is ignored in the clr_done cycle so requests get a turn
  assign clr_go   = (state_q == IDLE) && bus.clr_req && !done_q;
  assign grant_go = (state_q == IDLE) && !clr_go && win_v;

`ifdef REGS_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  assign start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++)
      if (grant_go && win[i]) ptr_d = IW'(wrap_inc(i, NREQ));
  end

  always_ff @(posedge clk or posedge cr) begin
    if (cr) ptr_q <= '0;
    else    ptr_q <= ptr_d;
  end
`else
  assign start = '0;
`endif

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_addr = bus.wr_addr[AW*i +: AW];
        sel_data = bus.wr_data[DW*i +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge cr) begin
    if (cr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      di_q    <= '0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (clr_go) state_d = CLR;
      CLR:  if (cnt_q == '1) state_d = IDLE;
    endcase
  end

  // cnt_q mirrors the address currently on the port during a clear
  always_comb begin
    cnt_d  = cnt_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    di_d   = di_q;
    gnt_d  = '0;
    done_d = 1'b0;
    unique case (1'b1)
      state_q == CLR: begin
        if (cnt_q == '1) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          we_d   = 1'b1;
          addr_d = cnt_q + 1'b1;
          di_d   = '0;
        end
      end
      clr_go: begin
        cnt_d  = '0;
        we_d   = 1'b1;
        addr_d = '0;
        di_d   = '0;
      end
      grant_go: begin
        we_d   = 1'b1;
        addr_d = sel_addr;
        di_d   = sel_data;
        gnt_d  = win;
      end
      default: ;
    endcase
  end

  assign bus.WE       = we_q;
  assign bus.Addr_W   = addr_q;
  assign bus.Di       = di_q;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = (state_q == CLR);
  assign bus.clr_done = done_q;

endmodule
